// File: rtl/stopwatch_seq.sv
// stopwatch_seq: three-button stopwatch with an optional lap FIFO.
// Each raw button goes through a 2-flop synchronizer and a rising-edge detector.
// A one-hot FSM (IDLE/CLEAR/RUNNING) gates a seconds prescaler and a seconds counter.
// Optional feature macro: STOPWATCH_SEQ_LAP_EN builds the lap FIFO. Without it,
// lap_i is ignored and every lap output is tied to 0.
// Ports:
//   clk, rst_i (async, active-high)
//   start_stop_i, clear_i, lap_i      raw buttons, asynchronous to clk
//   mode_o                            one-hot mode: IDLE=100, CLEAR=010, RUNNING=001
//   time_o, tick_o                    elapsed seconds and a one-cycle increment pulse
//   lap_valid_o, lap_data_o, lap_ready_i, lap_count_o, lap_ovf_o   lap FIFO head/handshake/status
module stopwatch_seq #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned TIME_W        = 5,
  parameter int unsigned LAP_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         start_stop_i,
  input  logic                         clear_i,
  input  logic                         lap_i,
  output logic [2:0]                   mode_o,
  output logic [TIME_W-1:0]            time_o,
  output logic                         tick_o,
  output logic                         lap_valid_o,
  output logic [TIME_W-1:0]            lap_data_o,
  input  logic                         lap_ready_i,
  output logic [$clog2(LAP_DEPTH):0]   lap_count_o,
  output logic                         lap_ovf_o
);

  localparam int unsigned PSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned CW  = $clog2(LAP_DEPTH) + 1;
  localparam int unsigned PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b100,
    S_CLEAR   = 3'b010,
    S_RUNNING = 3'b001
  } state_t;

  state_t state_q, state_d;

  // Button conditioning: bit 0 start_stop, bit 1 clear, bit 2 lap
  logic       lap_raw;
  logic [2:0] sync1_q, sync2_q, prev_q, ev;
  logic [1:0] wu_q, wu_d;

`ifdef STOPWATCH_SEQ_LAP_EN
  assign lap_raw = lap_i;
`else
  logic unused_lap;
  assign lap_raw    = 1'b0;
  assign unused_lap = ^{lap_i, lap_ready_i, ev[2]};
`endif

  // Warm-up counter masks events until the synchronizer holds real samples,
  // so a button held through reset release never looks like a fresh press.
  assign wu_d = (wu_q == 2'd3) ? wu_q : wu_q + 2'd1;
  assign ev   = sync2_q & ~prev_q & {3{wu_q == 2'd3}};

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      wu_q    <= '0;
    end else begin
      sync1_q <= {lap_raw, clear_i, start_stop_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      wu_q    <= wu_d;
    end
  end

  // FSM next state; clear wins over start_stop in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ev[1])      state_d = S_CLEAR;
        else if (ev[0]) state_d = S_RUNNING;
      end
      S_CLEAR:   if (ev[0]) state_d = S_RUNNING;
      S_RUNNING: if (ev[0]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  logic enter_clear, running;
  assign enter_clear = (state_d == S_CLEAR) && (state_q != S_CLEAR);
  assign running     = (state_q == S_RUNNING);

  // Prescaler and seconds counter; prescaler holds its phase while paused
  logic [PSW-1:0]    presc_q, presc_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    tick_d  = 1'b0;
    if (enter_clear) begin
      presc_d = '0;
      time_d  = '0;
    end else if (running) begin
      if (presc_q == PSW'(TICKS_PER_SEC - 1)) begin
        presc_d = '0;
        time_d  = time_q + TIME_W'(1);
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PSW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      time_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
    end
  end

  assign mode_o = state_q;
  assign time_o = time_q;
  assign tick_o = tick_q;

`ifdef STOPWATCH_SEQ_LAP_EN
  // Lap FIFO: a push while full succeeds only when a pop frees a slot the same cycle
  logic [TIME_W-1:0] mem_q [LAP_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              push_req, pop, full, do_push;

  assign push_req = ev[2] && running;
  assign pop      = (cnt_q != '0) && lap_ready_i;
  assign full     = (cnt_q == CW'(LAP_DEPTH));
  assign do_push  = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(LAP_DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (enter_clear) begin
      for (int i = 0; i < int'(LAP_DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= time_q;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      if (do_push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - CW'(1);
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign lap_valid_o = (cnt_q != '0);
  assign lap_data_o  = mem_q[rd_q];
  assign lap_count_o = cnt_q;
  assign lap_ovf_o   = ovf_q;
`else
  assign lap_valid_o = 1'b0;
  assign lap_data_o  = '0;
  assign lap_count_o = '0;
  assign lap_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq (default parameters: 100 ticks/s, 5-bit time, 4-deep laps).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_seq;
  localparam int unsigned TW = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst, ss, clr, lap, lap_ready;
  logic [2:0]    mode;
  logic [TW-1:0] time_v, lap_data;
  logic          tick, lap_valid, lap_ovf;
  logic [CW-1:0] lap_count;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_seq #(.TICKS_PER_SEC(100), .TIME_W(TW), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst_i(rst), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
    .mode_o(mode), .time_o(time_v), .tick_o(tick), .lap_valid_o(lap_valid),
    .lap_data_o(lap_data), .lap_ready_i(lap_ready), .lap_count_o(lap_count),
    .lap_ovf_o(lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 start_stop, 1 clear, 2 lap
  task automatic press(input int which, input int hold);
    case (which)
      0: ss = 1'b1;
      1: clr = 1'b1;
      default: lap = 1'b1;
    endcase
    cyc(hold);
    ss = 1'b0; clr = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic to_clear();
    do_reset();
    press(1, 2);
    cyc(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss = 1'b1; clr = 1'b1; lap = 1'b1; lap_ready = 1'b0;
    cyc(3);
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL reset_mode: got %b expected 100", mode); end
    n_checks++; if (time_v !== 5'd0) begin n_fail++; $display("FAIL reset_time: got %0d expected 0", time_v); end
    n_checks++; if (lap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lap_valid: got %b expected 0", lap_valid); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_checks++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL reset_lap_count: got %0d expected 0", lap_count); end
    rst = 1'b0;
    cyc(10);
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL held_through_reset_mode: got %b expected 100", mode); end
    ss = 1'b0; clr = 1'b0; lap = 1'b0;
    cyc(5);
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL release_after_reset_mode: got %b expected 100", mode); end
  endtask

  task automatic test_hold();
    logic [2:0] prev;
    int trans;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      prev = mode; trans = 0; ss = 1'b1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (mode !== prev) trans++;
        prev = mode;
        if (i == 20) ss = 1'b0;
      end
      n_checks++; if (trans != 1) begin n_fail++; $display("FAIL hold_transitions%0d: got %0d expected 1", pass, trans); end
      n_checks++;
      if (mode !== ((pass == 0) ? 3'b001 : 3'b100)) begin
        n_fail++; $display("FAIL hold_mode%0d: got %b expected %b", pass, mode, (pass == 0) ? 3'b001 : 3'b100);
      end
    end
  endtask

  task automatic test_start();
    int ticks;
    to_clear();
    n_checks++; if (mode !== 3'b010) begin n_fail++; $display("FAIL clear_mode: got %b expected 010", mode); end
    n_checks++; if (time_v !== 5'd0) begin n_fail++; $display("FAIL clear_time: got %0d expected 0", time_v); end
    ticks = 0; ss = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (i == 2) ss = 1'b0;
      if (tick === 1'b1) ticks++;
      if (i == 102) begin
        n_checks++; if (time_v !== 5'd0) begin n_fail++; $display("FAIL first_second_early: got %0d expected 0", time_v); end
      end
      if (i == 103) begin
        n_checks++; if (time_v !== 5'd1) begin n_fail++; $display("FAIL first_second: got %0d expected 1", time_v); end
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL first_tick: got %b expected 1", tick); end
      end
    end
    n_checks++; if (mode !== 3'b001) begin n_fail++; $display("FAIL run_mode: got %b expected 001", mode); end
    n_checks++; if (time_v !== 5'd2) begin n_fail++; $display("FAIL run_time: got %0d expected 2", time_v); end
    n_checks++; if (ticks != 2) begin n_fail++; $display("FAIL run_tick_count: got %0d expected 2", ticks); end
  endtask

  task automatic test_pause();
    int ticks;
    to_clear();
    ss = 1'b1;
    for (int i = 1; i <= 155; i++) begin
      @(negedge clk);
      if (i == 2 || i == 152) ss = 1'b0;
      if (i == 150) ss = 1'b1;
    end
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL pause_mode: got %b expected 100", mode); end
    n_checks++; if (time_v !== 5'd1) begin n_fail++; $display("FAIL pause_time: got %0d expected 1", time_v); end
    ticks = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0) begin n_fail++; $display("FAIL pause_ticks: got %0d expected 0", ticks); end
    n_checks++; if (time_v !== 5'd1) begin n_fail++; $display("FAIL pause_hold_time: got %0d expected 1", time_v); end
    ss = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      if (i == 2) ss = 1'b0;
      if (i == 52) begin
        n_checks++; if (time_v !== 5'd1) begin n_fail++; $display("FAIL resume_early: got %0d expected 1", time_v); end
      end
      if (i == 53) begin
        n_checks++; if (time_v !== 5'd2) begin n_fail++; $display("FAIL resume_phase: got %0d expected 2", time_v); end
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick: got %b expected 1", tick); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1; ss = 1'b1;
    #1;
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL async_reset_mode: got %b expected 100", mode); end
    n_checks++; if (time_v !== 5'd0) begin n_fail++; $display("FAIL async_reset_time: got %0d expected 0", time_v); end
    @(negedge clk);
    rst = 1'b0;
    cyc(10);
    n_checks++; if (mode !== 3'b100) begin n_fail++; $display("FAIL mid_reset_held_mode: got %b expected 100", mode); end
    ss = 1'b0;
    cyc(3);
  endtask

`ifdef STOPWATCH_SEQ_LAP_EN
  task automatic test_laps();
    int waited;
    to_clear();
    lap_ready = 1'b0;
    press(0, 2);
    for (int t = 1; t <= 5; t++) begin
      waited = 0;
      while (time_v !== TW'(t) && waited < 300) begin cyc(1); waited++; end
      n_checks++; if (waited >= 300) begin n_fail++; $display("FAIL lap_wait_time%0d: got %0d expected %0d", t, time_v, t); end
      press(2, 2);
      cyc(3);
    end
    n_checks++; if (lap_count !== 3'd4) begin n_fail++; $display("FAIL lap_count_full: got %0d expected 4", lap_count); end
    n_checks++; if (lap_ovf !== 1'b1) begin n_fail++; $display("FAIL lap_ovf_set: got %b expected 1", lap_ovf); end
    cyc(3);
    n_checks++; if (lap_data !== 5'd1) begin n_fail++; $display("FAIL lap_head_hold: got %0d expected 1", lap_data); end
    lap_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (lap_valid !== 1'b1 || lap_data !== TW'(k)) begin
        n_fail++; $display("FAIL lap_drain%0d: got valid=%b data=%0d expected valid=1 data=%0d", k, lap_valid, lap_data, k);
      end
      cyc(1);
    end
    n_checks++; if (lap_valid !== 1'b0) begin n_fail++; $display("FAIL lap_empty_valid: got %b expected 0", lap_valid); end
    n_checks++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL lap_empty_count: got %0d expected 0", lap_count); end
    lap_ready = 1'b0;
    press(0, 2);
    cyc(3);
    press(2, 2);
    cyc(4);
    n_checks++; if (lap_count !== 3'd0) begin n_fail++; $display("FAIL lap_idle_ignored: got %0d expected 0", lap_count); end
    n_checks++; if (lap_ovf !== 1'b1) begin n_fail++; $display("FAIL lap_ovf_sticky: got %b expected 1", lap_ovf); end
    press(1, 2);
    cyc(3);
    n_checks++; if (lap_ovf !== 1'b0) begin n_fail++; $display("FAIL lap_ovf_clear: got %b expected 0", lap_ovf); end
  endtask
`else
  task automatic test_laps_off();
    to_clear();
    lap_ready = 1'b0;
    press(0, 2);
    cyc(110);
    for (int k = 0; k < 3; k++) begin
      press(2, 2);
      cyc(4);
      n_checks++; if (lap_valid !== 1'b0 || lap_count !== 3'd0 || lap_data !== 5'd0 || lap_ovf !== 1'b0) begin
        n_fail++; $display("FAIL lap_disabled%0d: got valid=%b count=%0d data=%0d ovf=%b expected all 0", k, lap_valid, lap_count, lap_data, lap_ovf);
      end
    end
  endtask
`endif

  task automatic test_wrap();
    int ticks;
    to_clear();
    ticks = 0; ss = 1'b1;
    for (int i = 1; i <= 3205; i++) begin
      @(negedge clk);
      if (i == 2) ss = 1'b0;
      if (tick === 1'b1) ticks++;
      if (i == 3202) begin
        n_checks++; if (time_v !== 5'd31) begin n_fail++; $display("FAIL wrap_max: got %0d expected 31", time_v); end
      end
      if (i == 3203) begin
        n_checks++; if (time_v !== 5'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", time_v); end
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL wrap_tick: got %b expected 1", tick); end
      end
    end
    n_checks++; if (ticks != 32) begin n_fail++; $display("FAIL wrap_tick_count: got %0d expected 32", ticks); end
  endtask

  initial begin
    rst = 1'b1; ss = 1'b0; clr = 1'b0; lap = 1'b0; lap_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold();
    test_start();
    test_pause();
    test_reset_mid();
`ifdef STOPWATCH_SEQ_LAP_EN
    test_laps();
`else
    test_laps_off();
`endif
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
